// File: rtl/mult_arb_pkg.sv
// Shared constants and state encoding for the multiplier arbiter.
// TIMEOUT and CNT_W only matter when MULT_ARB_TIMEOUT_EN is defined.
package mult_arb_pkg;

  localparam int W       = 4;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RELEASE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mult_arbiter_rr.sv
// Combinational two-way round-robin picker: on a tie the client that was
// not served last wins.
module rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_gntValid,
  output logic o_gntIdx
);

  assign o_gntValid = i_req0 | i_req1;
  assign o_gntIdx   = (i_req0 & i_req1) ? ~i_last : i_req1;

endmodule

// File: rtl/mult_arbiter.sv
// Sequencer and round-robin arbiter in front of the shared 4x4 multiplier.
// Optional macro MULT_ARB_TIMEOUT_EN bounds WAIT and aborts with err.
module mult_arbiter
  import mult_arb_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_req0,
  input  logic           i_req1,
  input  logic [W-1:0]   i_a0,
  input  logic [W-1:0]   i_b0,
  input  logic [W-1:0]   i_a1,
  input  logic [W-1:0]   i_b1,
  output logic           o_done0,
  output logic           o_done1,
  output logic [2*W-1:0] o_res,
  output logic           o_err,
  output logic [W-1:0]   o_mSrc1,
  output logic [W-1:0]   o_mSrc2,
  output logic           o_mStart,
  output logic           o_mRst,
  input  logic [2*W-1:0] i_mResult,
  input  logic           i_mValid
);

  state_t           r_state;
  logic             r_gnt;
  logic             r_last;
  logic             r_done0;
  logic             r_done1;
  logic             r_start;
  logic [W-1:0]     r_src1;
  logic [W-1:0]     r_src2;
  logic [2*W-1:0]   r_res;
  logic             w_gntValid;
  logic             w_gntIdx;
`ifdef MULT_ARB_TIMEOUT_EN
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
`endif

  rr_arb2 u_rrArb (
    .i_req0     (i_req0),
    .i_req1     (i_req1),
    .i_last     (r_last),
    .o_gntValid (w_gntValid),
    .o_gntIdx   (w_gntIdx)
  );

  // Operands are latched once at grant and held until the operation retires.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_start <= 1'b0;
      r_src1  <= '0;
      r_src2  <= '0;
      r_res   <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      r_err   <= 1'b0;
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gntValid) begin
            r_gnt   <= w_gntIdx;
            r_src1  <= w_gntIdx ? i_a1 : i_a0;
            r_src2  <= w_gntIdx ? i_b1 : i_b0;
            r_start <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_start <= 1'b0;
          r_state <= RELEASE;
        end
        RELEASE: begin
`ifdef MULT_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_state <= WAIT;
        end
        WAIT: begin
          // A valid arriving in the expiry cycle still counts as a normal finish.
          if (i_mValid) begin
            r_res   <= i_mResult;
            r_done0 <= ~r_gnt;
            r_done1 <= r_gnt;
            r_state <= RESP;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_res   <= '0;
            r_err   <= 1'b1;
            r_done0 <= ~r_gnt;
            r_done1 <= r_gnt;
            r_state <= RESP;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
          r_err   <= 1'b0;
`endif
          r_last  <= r_gnt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_done0  = r_done0;
  assign o_done1  = r_done1;
  assign o_res    = r_res;
  assign o_mSrc1  = r_src1;
  assign o_mSrc2  = r_src2;
  assign o_mStart = r_start;

`ifdef MULT_ARB_TIMEOUT_EN
  // The abort cycle also resets the multiplier so a stuck operation is flushed.
  assign o_err  = r_err;
  assign o_mRst = ~(i_rst | ((r_state == RESP) & r_err));
`else
  assign o_err  = 1'b0;
  assign o_mRst = ~i_rst;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural multiplier model.
// Define MULT_ARB_TIMEOUT_EN to also exercise the timeout abort.
module tb_mult_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       done0, done1, err, mStart, mRst;
  logic [7:0] res, mResult;
  logic [3:0] mSrc1, mSrc2;
  logic       mValid;
  bit         hang;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    bit         client;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] expRes;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  mult_arbiter dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req0    (req0),
    .i_req1    (req1),
    .i_a0      (a0),
    .i_b0      (b0),
    .i_a1      (a1),
    .i_b1      (b1),
    .o_done0   (done0),
    .o_done1   (done1),
    .o_res     (res),
    .o_err     (err),
    .o_mSrc1   (mSrc1),
    .o_mSrc2   (mSrc2),
    .o_mStart  (mStart),
    .o_mRst    (mRst),
    .i_mResult (mResult),
    .i_mValid  (mValid)
  );

  // Multiplier model: captures operands in the cycle after start falls and
  // pulses valid with the product one cycle later.
  initial begin : multModel
    bit         prevStart;
    bit         pend;
    logic [7:0] pendRes;
    prevStart = 1'b0;
    pend      = 1'b0;
    pendRes   = '0;
    mValid    = 1'b0;
    mResult   = '0;
    forever begin
      @(posedge clk);
      #1;
      mValid = 1'b0;
      if (pend) begin
        mValid  = 1'b1;
        mResult = pendRes;
        pend    = 1'b0;
      end
      if (!mRst) pend = 1'b0;
      else if (prevStart && !mStart && !hang) begin
        pend    = 1'b1;
        pendRes = {4'b0, mSrc1} * {4'b0, mSrc2};
      end
      prevStart = mStart;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the negedge of the first cycle with reset low.
  task automatic applyReset();
    rst = 1'b1;
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("rst mRst", 32'(mRst), 32'd0);
    checkOutput("rst done0", 32'(done0), 32'd0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-rst start", 32'(mStart), 32'd0);
    checkOutput("post-rst done", 32'({done0, done1}), 32'd0);
    checkOutput("post-rst res", 32'(res), 32'd0);
    checkOutput("post-rst src", 32'({mSrc1, mSrc2}), 32'd0);
    checkOutput("post-rst err", 32'(err), 32'd0);
    checkOutput("post-rst mRst", 32'(mRst), 32'd1);
  endtask

  task automatic applyStimulus(input bit client, input logic [3:0] a, input logic [3:0] b,
                               input logic [7:0] expRes);
    nextCycle();
    if (client) begin req1 = 1'b1; a1 = a; b1 = b; end
    else        begin req0 = 1'b1; a0 = a; b0 = b; end
    @(negedge clk);
    checkOutput("op c0 start", 32'(mStart), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      nextCycle();
      if (c == 5) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      checkOutput($sformatf("op c%0d start", c), 32'(mStart), 32'(c == 1));
      if (c == 1) checkOutput("op src", 32'({mSrc1, mSrc2}), 32'({a, b}));
      checkOutput($sformatf("op c%0d done0", c), 32'(done0), 32'(c == 4 && !client));
      checkOutput($sformatf("op c%0d done1", c), 32'(done1), 32'(c == 4 && client));
      if (c >= 4) checkOutput($sformatf("op c%0d res", c), 32'(res), 32'(expRes));
      checkOutput($sformatf("op c%0d err", c), 32'(err), 32'd0);
      checkOutput($sformatf("op c%0d mRst", c), 32'(mRst), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; hang = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    vecs[0] = '{1'b0, 4'd13, 4'd11, 8'd143};
    vecs[1] = '{1'b0, 4'hF,  4'hF,  8'hE1};
    vecs[2] = '{1'b1, 4'd0,  4'h9,  8'd0};
    vecs[3] = '{1'b1, 4'hF,  4'hF,  8'hE1};
    vecs[4] = '{1'b0, 4'd7,  4'd9,  8'd63};
    vecs[5] = '{1'b1, 4'd1,  4'hF,  8'd15};

    applyReset();
    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i].client, vecs[i].a, vecs[i].b, vecs[i].expRes);

    // Reset pulsed while the operation sits in WAIT.
    nextCycle();
    req0 = 1'b1; a0 = 4'd9; b0 = 4'd9;
    repeat (2) nextCycle();
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstWait mRst", 32'(mRst), 32'd0);
    nextCycle();
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    checkOutput("rstWait done", 32'({done0, done1}), 32'd0);
    checkOutput("rstWait start", 32'(mStart), 32'd0);
    checkOutput("rstWait res", 32'(res), 32'd0);
    checkOutput("rstWait src", 32'({mSrc1, mSrc2}), 32'd0);
    checkOutput("rstWait err", 32'(err), 32'd0);
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("rstWait no done", 32'({done0, done1}), 32'd0);
    end
    applyStimulus(1'b0, 4'd2, 4'd3, 8'd6);

    // Tie from reset, then both held: grants alternate 0,1,0,1.
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
    req1 = 1'b1; a1 = 4'd6; b1 = 4'd7;
    applyReset();
    for (int c = 1; c <= 20; c++) begin
      nextCycle();
      if (c == 20) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      checkOutput($sformatf("tie c%0d done0", c), 32'(done0), 32'(c == 4 || c == 14));
      checkOutput($sformatf("tie c%0d done1", c), 32'(done1), 32'(c == 9 || c == 19));
      if (c == 4 || c == 14) checkOutput($sformatf("tie c%0d res", c), 32'(res), 32'd15);
      if (c == 9 || c == 19) checkOutput($sformatf("tie c%0d res", c), 32'(res), 32'd42);
      if (c == 6) checkOutput("tie src c6", 32'({mSrc1, mSrc2}), 32'({4'd6, 4'd7}));
    end

`ifdef MULT_ARB_TIMEOUT_EN
    // Multiplier never answers; abort lands 8 cycles after entering WAIT.
    hang = 1'b1;
    nextCycle();
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd6;
    for (int c = 1; c <= 12; c++) begin
      nextCycle();
      if (c == 12) req0 = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("tmo c%0d done0", c), 32'(done0), 32'(c == 11));
      checkOutput($sformatf("tmo c%0d err", c), 32'(err), 32'(c == 11));
      checkOutput($sformatf("tmo c%0d mRst", c), 32'(mRst), 32'(c != 11));
      if (c == 11) checkOutput("tmo res", 32'(res), 32'd0);
    end
    hang = 1'b0;
`endif

    // Random traffic against a cycle-count model of the arbiter.
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    applyReset();
    begin
      int         busy;
      int         doneAt;
      bit         mLast;
      bit         expW;
      bit         drop0, drop1;
      logic [7:0] expP;
      busy = 0; doneAt = -1; mLast = 1'b1; expW = 1'b0;
      drop0 = 1'b0; drop1 = 1'b0; expP = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        nextCycle();
        if (drop0) begin req0 = 1'b0; drop0 = 1'b0; end
        else if (!req0 && cyc < 580 && $urandom_range(0, 2) == 0) begin
          req0 = 1'b1; a0 = 4'($urandom); b0 = 4'($urandom);
        end
        if (drop1) begin req1 = 1'b0; drop1 = 1'b0; end
        else if (!req1 && cyc < 580 && $urandom_range(0, 2) == 0) begin
          req1 = 1'b1; a1 = 4'($urandom); b1 = 4'($urandom);
        end
        if (busy == 0 && (req0 || req1)) begin
          expW   = (req0 && req1) ? ~mLast : req1;
          mLast  = expW;
          expP   = expW ? {4'b0, a1} * {4'b0, b1} : {4'b0, a0} * {4'b0, b0};
          doneAt = cyc + 4;
          busy   = 5;
        end
        @(negedge clk);
        checkOutput($sformatf("rnd c%0d done0", cyc), 32'(done0), 32'(cyc == doneAt && !expW));
        checkOutput($sformatf("rnd c%0d done1", cyc), 32'(done1), 32'(cyc == doneAt && expW));
        if (cyc == doneAt) begin
          checkOutput($sformatf("rnd c%0d res", cyc), 32'(res), 32'(expP));
          if (expW) drop1 = 1'b1;
          else      drop0 = 1'b1;
        end
        if (busy > 0) busy--;
      end
      req0 = 1'b0; req1 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
